// File: rtl/vend_txn_ctrl.sv
// Purchase sequencer for the vending machine: lane confirm, coin accumulation,
// success/refund decision, dispense pulse and running turnover/sold totals.
module vend_txn_ctrl #(
    parameter logic [31:0] HOLD_CYCLES    = 32'd100_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [2:0]  customerchoose,
    input  logic        confirm,
    input  logic        cancel_btn,
    input  logic        coin1,
    input  logic        coin5,
    input  logic        coin10,
    input  logic [3:0]  costone,
    input  logic [3:0]  costten,
    input  logic [20:0] goodleft,
    output logic        enterpay,
    output logic        paysuccessful,
    output logic        endpay,
    output logic [3:0]  paidone,
    output logic [3:0]  paidten,
    output logic [3:0]  returnone,
    output logic [3:0]  returnten,
    output logic        dispense,
    output logic [2:0]  dispense_lane,
    output logic        soldout,
    output logic [3:0]  turnover1,
    output logic [3:0]  turnover10,
    output logic [3:0]  sold1,
    output logic [3:0]  sold10
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAY     = 2'd1,
        ST_SUCCESS = 2'd2,
        ST_FAIL    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  cost_q, cost_d;
    logic [6:0]  paid_q, paid_d;
    logic [6:0]  ret_q, ret_d;
    logic [2:0]  lane_q, lane_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] hold_q, hold_d;
    logic [6:0]  turn_q, turn_d;
    logic [6:0]  sold_q, sold_d;
    logic        dispense_q, dispense_d;
    logic        soldout_q, soldout_d;

    logic        coin_hit_s;
    logic [6:0]  coin_val_s;
    logic [7:0]  paid_sum_s;
    logic [6:0]  next_paid_s;
    logic [7:0]  turn_sum_s;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [2:0] lane_stock(input logic [20:0] g, input logic [2:0] lane);
        logic [2:0] s;
        case (lane)
            3'd1:    s = g[2:0];
            3'd2:    s = g[5:3];
            3'd3:    s = g[8:6];
            3'd4:    s = g[11:9];
            3'd5:    s = g[14:12];
            3'd6:    s = g[17:15];
            3'd7:    s = g[20:18];
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    // Coin priority decode and saturating next-paid value.
    always_comb begin
        coin_hit_s = coin10 | coin5 | coin1;
        if (coin10) begin
            coin_val_s = 7'd10;
        end else if (coin5) begin
            coin_val_s = 7'd5;
        end else if (coin1) begin
            coin_val_s = 7'd1;
        end else begin
            coin_val_s = 7'd0;
        end
        paid_sum_s  = {1'b0, paid_q} + {1'b0, coin_val_s};
        next_paid_s = (paid_sum_s >= 8'd99) ? 7'd99 : paid_sum_s[6:0];
        turn_sum_s  = {1'b0, turn_q} + {1'b0, cost_q};
    end

    // Next-state and datapath updates for the purchase sequence.
    always_comb begin
        state_d    = state_q;
        cost_d     = cost_q;
        paid_d     = paid_q;
        ret_d      = ret_q;
        lane_d     = lane_q;
        timer_d    = timer_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        sold_d     = sold_q;
        dispense_d = 1'b0;
        soldout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (confirm && !mode && (customerchoose != 3'd0)) begin
                    if (lane_stock(goodleft, customerchoose) == 3'd0) begin
                        soldout_d = 1'b1;
                    end else begin
                        lane_d  = customerchoose;
                        cost_d  = (7'(costten) * 7'd10) + 7'(costone);
                        paid_d  = 7'd0;
                        ret_d   = 7'd0;
                        timer_d = 32'd0;
                        state_d = ST_PAY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAY: begin
                // Expiry needs a coinless current cycle; a coin here restarts the wait.
                if (cancel_btn || mode ||
                    ((timer_q == TIMEOUT_CYCLES - 32'd1) && !coin_hit_s)) begin
                    ret_d   = paid_q;
                    hold_d  = 32'd0;
                    state_d = ST_FAIL;
                end else begin
                    paid_d  = next_paid_s;
                    timer_d = coin_hit_s ? 32'd0 : timer_q + 32'd1;
                    if (next_paid_s >= cost_q) begin
                        ret_d      = next_paid_s - cost_q;
                        hold_d     = 32'd0;
                        dispense_d = 1'b1;
                        turn_d     = (turn_sum_s >= 8'd100) ? 7'(turn_sum_s - 8'd100) : turn_sum_s[6:0];
                        sold_d     = (sold_q == 7'd99) ? 7'd0 : sold_q + 7'd1;
                        state_d    = ST_SUCCESS;
                    end else begin
                        state_d = ST_PAY;
                    end
                end
            end
            ST_SUCCESS, ST_FAIL: begin
                if (hold_q == HOLD_CYCLES - 32'd1) begin
                    paid_d  = 7'd0;
                    ret_d   = 7'd0;
                    hold_d  = 32'd0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cost_q     <= 7'd0;
            paid_q     <= 7'd0;
            ret_q      <= 7'd0;
            lane_q     <= 3'd0;
            timer_q    <= 32'd0;
            hold_q     <= 32'd0;
            turn_q     <= 7'd0;
            sold_q     <= 7'd0;
            dispense_q <= 1'b0;
            soldout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cost_q     <= cost_d;
            paid_q     <= paid_d;
            ret_q      <= ret_d;
            lane_q     <= lane_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            sold_q     <= sold_d;
            dispense_q <= dispense_d;
            soldout_q  <= soldout_d;
        end
    end

    assign enterpay                 = (state_q == ST_PAY);
    assign paysuccessful            = (state_q == ST_SUCCESS);
    assign endpay                   = (state_q == ST_SUCCESS) || (state_q == ST_FAIL);
    assign {paidten, paidone}       = to_bcd(paid_q);
    assign {returnten, returnone}   = to_bcd(ret_q);
    assign {turnover10, turnover1}  = to_bcd(turn_q);
    assign {sold10, sold1}          = to_bcd(sold_q);
    assign dispense                 = dispense_q;
    assign dispense_lane            = lane_q;
    assign soldout                  = soldout_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed purchases plus randomized
// transactions compared against a transaction-level reference model.
module tb_vend_txn_ctrl;
    localparam int HOLD = 4;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [2:0]  customerchoose = 3'd0;
    logic        confirm = 1'b0, cancel_btn = 1'b0;
    logic        coin1 = 1'b0, coin5 = 1'b0, coin10 = 1'b0;
    logic [3:0]  costone = 4'd0, costten = 4'd0;
    logic [20:0] goodleft = 21'd0;
    logic        enterpay, paysuccessful, endpay, dispense, soldout;
    logic [3:0]  paidone, paidten, returnone, returnten;
    logic [3:0]  turnover1, turnover10, sold1, sold10;
    logic [2:0]  dispense_lane;

    vend_txn_ctrl #(.HOLD_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd20)) dut (
        .clk(clk), .rst(rst), .mode(mode), .customerchoose(customerchoose),
        .confirm(confirm), .cancel_btn(cancel_btn), .coin1(coin1), .coin5(coin5),
        .coin10(coin10), .costone(costone), .costten(costten), .goodleft(goodleft),
        .enterpay(enterpay), .paysuccessful(paysuccessful), .endpay(endpay),
        .paidone(paidone), .paidten(paidten), .returnone(returnone),
        .returnten(returnten), .dispense(dispense), .dispense_lane(dispense_lane),
        .soldout(soldout), .turnover1(turnover1), .turnover10(turnover10),
        .sold1(sold1), .sold10(sold10)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int turn_m  = 0;
    int sold_m  = 0;
    logic [2:0] plan[$];
    int  abort_kind = 0;
    int  abort_at   = 0;
    bit  rand_coins = 1'b0;
    int  pay_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input bit ep, input bit ps, input bit edp,
                              input int paid, input int ret, input bit disp);
        check({tag, "_enterpay"}, 32'(enterpay), 32'(ep));
        check({tag, "_paysucc"}, 32'(paysuccessful), 32'(ps));
        check({tag, "_endpay"}, 32'(endpay), 32'(edp));
        check({tag, "_paid"}, 32'({paidten, paidone}), 32'(bcd(paid)));
        check({tag, "_return"}, 32'({returnten, returnone}), 32'(bcd(ret)));
        check({tag, "_dispense"}, 32'(dispense), 32'(disp));
        check({tag, "_turnover"}, 32'({turnover10, turnover1}), 32'(bcd(turn_m)));
        check({tag, "_sold"}, 32'({sold10, sold1}), 32'(bcd(sold_m)));
    endtask

    task automatic set_lane(input int lane, input int stock, input int cost);
        for (int n = 1; n <= 7; n++)
            goodleft[3*n-3 +: 3] = (n == lane) ? 3'(stock) : 3'($urandom_range(0, 7));
        {costten, costone} = bcd(cost);
        customerchoose = 3'(lane);
    endtask

    // One purchase: reference model decides each PAY cycle from the rules.
    task automatic txn(input string tag, input int lane, input int stock, input int cost);
        int paid_m, ret_m, timer, cyc, v;
        bit done, succ;
        logic [2:0] c;
        set_lane(lane, stock, cost);
        mode = 1'b0;
        confirm = 1'b1;
        {coin10, coin5, coin1} = 3'($urandom);
        step();
        confirm = 1'b0;
        {coin10, coin5, coin1} = 3'd0;
        if (stock == 0) begin
            check({tag, "_soldout"}, 32'(soldout), 32'd1);
            check_outs({tag, "_so"}, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
            step();
            check({tag, "_soldout_end"}, 32'(soldout), 32'd0);
            check({tag, "_so_idle"}, 32'(enterpay), 32'd0);
            plan.delete();
            return;
        end
        check_outs({tag, "_cf"}, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        paid_m = 0; ret_m = 0; timer = 0; cyc = 0; done = 1'b0; succ = 1'b0;
        while (!done && cyc < 300) begin
            if (plan.size() > 0) c = plan.pop_front();
            else if (rand_coins && abort_kind != 3 && $urandom_range(0, 1) == 1) c = 3'($urandom);
            else c = 3'd0;
            cancel_btn = (abort_kind == 1 && cyc == abort_at);
            mode       = (abort_kind == 2 && cyc == abort_at);
            {coin10, coin5, coin1} = c;
            if (cancel_btn || mode || (timer == TO - 1 && c == 3'd0)) begin
                ret_m = paid_m; done = 1'b1;
            end else begin
                v = c[2] ? 10 : c[1] ? 5 : c[0] ? 1 : 0;
                paid_m = (paid_m + v > 99) ? 99 : paid_m + v;
                timer  = (c != 3'd0) ? 0 : timer + 1;
                if (paid_m >= cost) begin
                    ret_m = paid_m - cost; done = 1'b1; succ = 1'b1;
                    turn_m = (turn_m + cost) % 100;
                    sold_m = (sold_m + 1) % 100;
                end
            end
            step();
            cancel_btn = 1'b0; mode = 1'b0; {coin10, coin5, coin1} = 3'd0;
            cyc++;
            if (!done) check_outs({tag, "_pay"}, 1'b1, 1'b0, 1'b0, paid_m, 0, 1'b0);
            else       check_outs({tag, "_end"}, 1'b0, succ, 1'b1, paid_m, ret_m, succ);
        end
        if (!done) check({tag, "_bound"}, 32'd0, 32'd1);
        check({tag, "_lane"}, 32'(dispense_lane), 32'(lane));
        pay_cyc = cyc;
        for (int k = 1; k <= HOLD; k++) begin
            confirm = 1'($urandom); cancel_btn = 1'($urandom);
            {coin10, coin5, coin1} = 3'($urandom);
            step();
            confirm = 1'b0; cancel_btn = 1'b0; {coin10, coin5, coin1} = 3'd0;
            if (k < HOLD) check_outs({tag, "_hold"}, 1'b0, succ, 1'b1, paid_m, ret_m, 1'b0);
            else          check_outs({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        end
        plan.delete();
    endtask

    initial begin
        #2 rst = 1'b0;
        step();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("reset_lane", 32'(dispense_lane), 32'd0);
        check("reset_soldout", 32'(soldout), 32'd0);
        @(negedge clk) rst = 1'b1;
        step();

        // Exact pay.
        plan.push_back(3'b010);
        txn("exact", 2, 3, 5);
        check("exact_turn", 32'({turnover10, turnover1}), 32'h05);
        check("exact_sold", 32'({sold10, sold1}), 32'h01);

        // Overpay: coin10, then coin5+coin1 together -> only coin5 counted.
        plan.push_back(3'b100); plan.push_back(3'b011);
        txn("overpay", 4, 2, 12);
        check("overpay_turn", 32'({turnover10, turnover1}), 32'h17);

        // Cancel after paying 6 of 8.
        plan.push_back(3'b010); plan.push_back(3'b001);
        abort_kind = 1; abort_at = 2;
        txn("cancel", 1, 5, 8);
        abort_kind = 3;
        txn("timeout", 3, 5, 8);
        check("timeout_cycles", 32'(pay_cyc), 32'd20);
        abort_kind = 2; abort_at = 0;
        txn("modesw", 5, 5, 8);
        check("modesw_cycles", 32'(pay_cyc), 32'd1);
        abort_kind = 0;

        // Sold out, admin-mode confirm, and no-lane confirm are all rejected.
        txn("soldout", 7, 0, 10);
        set_lane(6, 4, 10);
        mode = 1'b1; confirm = 1'b1;
        step();
        mode = 1'b0; confirm = 1'b0;
        check("admin_confirm", 32'({enterpay, soldout}), 32'd0);
        customerchoose = 3'd0; confirm = 1'b1;
        step();
        confirm = 1'b0;
        check("nolane_confirm", 32'({enterpay, soldout}), 32'd0);

        // Cost 0 succeeds on the first PAY cycle; saturation at 99.
        txn("free", 6, 1, 0);
        check("free_cycles", 32'(pay_cyc), 32'd1);
        for (int i = 0; i < 11; i++) plan.push_back(3'b100);
        txn("sat", 1, 7, 99);
        check("sat_cycles", 32'(pay_cyc), 32'd10);

        // Randomized purchases.
        rand_coins = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            abort_kind = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            abort_at = $urandom_range(0, 5);
            txn("rand", $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 40));
        end
        abort_kind = 0; rand_coins = 1'b0;

        // Wrap: bring sold to 99 and turnover to 95, then buy at 10.
        while (sold_m != 98) txn("fill", 2, 3, 0);
        for (int i = 0; i < 10; i++) plan.push_back(3'b100);
        txn("pre", 3, 3, (195 - turn_m) % 100);
        check("pre_sold", 32'({sold10, sold1}), 32'h99);
        check("pre_turn", 32'({turnover10, turnover1}), 32'h95);
        plan.push_back(3'b100);
        txn("wrap", 4, 3, 10);
        check("wrap_sold", 32'({sold10, sold1}), 32'h00);
        check("wrap_turn", 32'({turnover10, turnover1}), 32'h05);

        // Asynchronous reset in the middle of PAY with paid 07.
        set_lane(3, 5, 20);
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        coin5 = 1'b1; step(); coin5 = 1'b0;
        coin1 = 1'b1; step(); step(); coin1 = 1'b0;
        check("rst_pre_paid", 32'({paidten, paidone}), 32'h07);
        #2 rst = 1'b0;
        #1;
        turn_m = 0; sold_m = 0;
        check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("rst_mid_lane", 32'(dispense_lane), 32'd0);
        check("rst_mid_soldout", 32'(soldout), 32'd0);
        @(negedge clk) rst = 1'b1;
        step();
        check_outs("rst_after", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
